// File: rtl/stream_demux.sv
// stream_demux: one-input, N-output valid/ready packet demultiplexer with one registered output stage.
// Optional build macro STREAM_DEMUX_DROP_EN: out-of-range first-beat selects drop the packet and count it.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SW-1:0]    up_sel,
  input  logic             up_last,
  output logic [N-1:0]     down_valid,
  input  logic [N-1:0]     down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_last,
  output logic [7:0]       drop_cnt
);

`ifdef STREAM_DEMUX_DROP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1} state_t;
`endif

  function automatic logic sel_oob(input logic [SW-1:0] s);
    return 32'(s) >= N;
  endfunction

  function automatic logic [SW-1:0] clamp_sel(input logic [SW-1:0] s);
    if (sel_oob(s)) return SW'(N - 1);
    return s;
  endfunction

`ifdef STREAM_DEMUX_DROP_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [SW-1:0]     dest_q, dest_d;
  logic [SW-1:0]     beat_dest;
  logic              drop_beat;
  logic              drop_start;
  logic              accept;
  logic              store;
  logic              consume_rdy;

  logic              out_full_p1;
  logic [SW-1:0]     out_dest_p1;
  logic [WIDTH-1:0]  out_data_p1;
  logic              out_last_p1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      down_valid[i] = out_full_p1 && (32'(out_dest_p1) == i);
    end
  end

  // down_valid is one-hot, so this picks the addressed port's ready and ignores the rest
  assign consume_rdy = |(down_valid & down_ready);
  assign down_data   = out_data_p1;
  assign down_last   = out_last_p1;

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    beat_dest  = dest_q;
    drop_beat  = 1'b0;
    drop_start = 1'b0;
    case (state_q)
      IDLE: begin
        beat_dest = clamp_sel(up_sel);
`ifdef STREAM_DEMUX_DROP_EN
        drop_beat = sel_oob(up_sel);
`endif
      end
`ifdef STREAM_DEMUX_DROP_EN
      DROP:    drop_beat = 1'b1;
`endif
      default: ;
    endcase

    // dropped beats never touch the output register, so they are always accepted
    up_ready = drop_beat || !out_full_p1 || consume_rdy;
    accept   = up_valid && up_ready;
    store    = accept && !drop_beat;

    if (accept) begin
      if (state_q == IDLE) begin
        dest_d = beat_dest;
        if (!up_last) state_d = PKT;
`ifdef STREAM_DEMUX_DROP_EN
        if (drop_beat) begin
          drop_start = 1'b1;
          if (!up_last) state_d = DROP;
        end
`endif
      end else if (up_last) begin
        state_d = IDLE;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      out_full_p1 <= 1'b0;
      out_dest_p1 <= '0;
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      if (store) begin
        out_full_p1 <= 1'b1;
        out_dest_p1 <= beat_dest;
        out_data_p1 <= up_data;
        out_last_p1 <= up_last;
      end else if (consume_rdy) begin
        out_full_p1 <= 1'b0;
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else if (drop_start) begin
      drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
  logic unused_drop;
  assign unused_drop = drop_start;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed, table-driven bench for stream_demux (N=3, WIDTH=8) plus hand-written reset and drop sequences.
module tb_stream_demux;
  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int SW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic [SW-1:0]    up_sel;
  logic             up_last;
  logic [N-1:0]     down_valid;
  logic [N-1:0]     down_ready;
  logic [WIDTH-1:0] down_data;
  logic             down_last;
  logic [7:0]       drop_cnt;

  stream_demux #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_sel(up_sel), .up_last(up_last),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_last(down_last),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          v;
    logic [SW-1:0] sel;
    logic [7:0]    data;
    logic          last;
    logic [N-1:0]  rdy;
    logic          exp_ur;
    logic [N-1:0]  exp_dv;
    logic [7:0]    exp_data;
    logic          exp_last;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic v, input int sel, input int data, input logic last,
                     input logic [N-1:0] rdy, input logic ur, input logic [N-1:0] dv,
                     input int ed, input logic el);
    vec_t t;
    t.name = n; t.v = v; t.sel = SW'(sel); t.data = 8'(data); t.last = last; t.rdy = rdy;
    t.exp_ur = ur; t.exp_dv = dv; t.exp_data = 8'(ed); t.exp_last = el;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input int sel, input int data, input logic last, input logic [N-1:0] rdy);
    up_valid = v; up_sel = SW'(sel); up_data = 8'(data); up_last = last; down_ready = rdy;
  endtask

  localparam logic [N-1:0] R = 3'b111;

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset down_valid", 32'(down_valid), 32'd0);
    check("reset up_ready",   32'(up_ready),   32'd1);
    check("reset drop_cnt",   32'(drop_cnt),   32'd0);
    check("reset down_data",  32'(down_data),  32'd0);
    check("reset down_last",  32'(down_last),  32'd0);

    // name, v, sel, data, last, ready, exp up_ready, exp down_valid, exp data, exp last
    add("single",  1, 1, 'hA5, 1, R, 1, 3'b010, 'hA5, 1);
    add("b2b0",    1, 0, 'h10, 1, R, 1, 3'b001, 'h10, 1);
    add("b2b1",    1, 1, 'h11, 1, R, 1, 3'b010, 'h11, 1);
    add("b2b2",    1, 2, 'h12, 1, R, 1, 3'b100, 'h12, 1);
    add("b2b3",    1, 0, 'h13, 1, R, 1, 3'b001, 'h13, 1);
    add("b2b4",    1, 1, 'h14, 1, R, 1, 3'b010, 'h14, 1);
    add("b2b5",    1, 2, 'h15, 1, R, 1, 3'b100, 'h15, 1);
    add("b2b6",    1, 0, 'h16, 1, R, 1, 3'b001, 'h16, 1);
    add("b2b7",    1, 1, 'h17, 1, R, 1, 3'b010, 'h17, 1);
    add("lock0",   1, 2, 'h20, 0, R, 1, 3'b100, 'h20, 0);
    add("lock1",   1, 0, 'h21, 0, R, 1, 3'b100, 'h21, 0);
    add("lock2",   1, 0, 'h22, 1, R, 1, 3'b100, 'h22, 1);
    add("postlock",1, 0, 'h23, 1, R, 1, 3'b001, 'h23, 1);
    add("idle0",   0, 0, 'h00, 0, R, 1, 3'b000, 0, 0);
    add("bp_load", 1, 0, 'h30, 1, 3'b110, 1, 3'b001, 'h30, 1);
    for (int k = 0; k < 4; k++)
      add("bp_hold", 1, 1, 'h31, 1, 3'b110, 0, 3'b001, 'h30, 1);
    add("bp_rel",  1, 1, 'h31, 1, R, 1, 3'b010, 'h31, 1);
    add("bp_next", 1, 1, 'h32, 1, R, 1, 3'b010, 'h32, 1);
    add("idle1",   0, 0, 'h00, 0, R, 1, 3'b000, 0, 0);
`ifdef STREAM_DEMUX_DROP_EN
    add("oor0",    1, 3, 'h40, 0, R, 1, 3'b000, 0, 0);
    add("oor1",    1, 0, 'h41, 1, R, 1, 3'b000, 0, 0);
`else
    add("oor0",    1, 3, 'h40, 0, R, 1, 3'b100, 'h40, 0);
    add("oor1",    1, 0, 'h41, 1, R, 1, 3'b100, 'h41, 1);
`endif
    add("idle2",   0, 0, 'h00, 0, R, 1, 3'b000, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, 32'(vecs[i].sel), 32'(vecs[i].data), vecs[i].last, vecs[i].rdy);
      #1;
      check($sformatf("%s[%0d] up_ready", vecs[i].name, i), 32'(up_ready), 32'(vecs[i].exp_ur));
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] down_valid", vecs[i].name, i), 32'(down_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv != '0) begin
        check($sformatf("%s[%0d] down_data", vecs[i].name, i), 32'(down_data), 32'(vecs[i].exp_data));
        check($sformatf("%s[%0d] down_last", vecs[i].name, i), 32'(down_last), 32'(vecs[i].exp_last));
      end
    end

`ifdef STREAM_DEMUX_DROP_EN
    check("drop_cnt after oor", 32'(drop_cnt), 32'd1);
`else
    check("drop_cnt after oor", 32'(drop_cnt), 32'd0);
`endif

    // reset in the middle of a 4-beat packet to port 1
    drive(1'b1, 1, 'h50, 1'b0, R);
    @(posedge clk);
    #1 check("rst beat1 down_valid", 32'(down_valid), 32'b010);
    drive(1'b1, 1, 'h51, 1'b0, R);
    #1 rst = 1'b1;
    #1;
    check("rst async down_valid", 32'(down_valid), 32'd0);
    check("rst async up_ready",   32'(up_ready),   32'd1);
    check("rst drop_cnt",         32'(drop_cnt),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst released down_valid", 32'(down_valid), 32'd0);
    drive(1'b1, 0, 'h60, 1'b1, R);
    @(posedge clk);
    #1;
    check("post-rst down_valid", 32'(down_valid), 32'b001);
    check("post-rst down_data",  32'(down_data),  32'h60);
    check("post-rst down_last",  32'(down_last),  32'd1);
    drive(1'b0, 0, 0, 1'b0, R);
    @(posedge clk);
    #1 check("final drain down_valid", 32'(down_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
